// File: rtl/card_dealer_pkg.sv
// Shared types and deck constants for the card dealer and its consumers.
// Category decode helper lets game logic map a dealt index to suspect/weapon/room.
package card_dealer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        SCAN  = 2'd2,
        OFFER = 2'd3
    } dealer_state_e;

    typedef enum logic [1:0] {
        CAT_SUSPECT = 2'd0,
        CAT_WEAPON  = 2'd1,
        CAT_ROOM    = 2'd2,
        CAT_INVALID = 2'd3
    } card_cat_e;

    localparam int NUM_SUSPECTS   = 6;
    localparam int NUM_WEAPONS    = 6;
    localparam int NUM_ROOMS      = 9;
    localparam int SUSPECT_BASE   = 0;
    localparam int WEAPON_BASE    = 6;
    localparam int ROOM_BASE      = 12;
    localparam int CLUE_DECK_SIZE = NUM_SUSPECTS + NUM_WEAPONS + NUM_ROOMS;

    function automatic card_cat_e card_category(input logic [4:0] idx);
        card_cat_e cat;
        if (int'(idx) < WEAPON_BASE) begin
            cat = CAT_SUSPECT;
        end else if (int'(idx) < ROOM_BASE) begin
            cat = CAT_WEAPON;
        end else if (int'(idx) < CLUE_DECK_SIZE) begin
            cat = CAT_ROOM;
        end else begin
            cat = CAT_INVALID;
        end
        return cat;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Card delivery handshake between the dealer (master) and the game logic (slave).
// CARD_DEALER_STATS_EN adds the rejection counter and scan-used flag.
interface card_dealer_if #(
    parameter int IDX_WIDTH = 5
);
    logic                 card_valid;
    logic                 card_ready;
    logic [IDX_WIDTH-1:0] card_idx;
    logic [IDX_WIDTH:0]   deal_count;
    logic                 done;
`ifdef CARD_DEALER_STATS_EN
    logic [15:0]          reject_total;
    logic                 scan_used;
`endif

    modport master (
        output card_valid,
        output card_idx,
        output deal_count,
        output done,
`ifdef CARD_DEALER_STATS_EN
        output reject_total,
        output scan_used,
`endif
        input  card_ready
    );

    modport slave (
        input  card_valid,
        input  card_idx,
        input  deal_count,
        input  done,
`ifdef CARD_DEALER_STATS_EN
        input  reject_total,
        input  scan_used,
`endif
        output card_ready
    );

endinterface

// File: rtl/card_dealer_dealt_scan.sv
// Find-first-zero over the dealt mask: lowest undealt index plus a found flag.
module dealt_scan #(
    parameter int NUM_CARDS = 21,
    parameter int IDX_WIDTH = 5
) (
    input  logic [NUM_CARDS-1:0] i_mask,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    // Walk from the top down so the lowest zero bit is the last one written.
    always_comb begin
        o_idx   = {IDX_WIDTH{1'b0}};
        o_found = 1'b0;
        for (int i = NUM_CARDS - 1; i >= 0; i--) begin
            o_idx   = i_mask[i] ? o_idx : IDX_WIDTH'(i);
            o_found = o_found | ~i_mask[i];
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals a no-repeat permutation of NUM_CARDS indices by rejection sampling rand_in,
// with a scan fallback after MAX_TRIES rejections. Optional stats: CARD_DEALER_STATS_EN.
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter int RAND_WIDTH = 32,
    parameter int NUM_CARDS  = 21,
    parameter int IDX_WIDTH  = 5,
    parameter int MAX_TRIES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RAND_WIDTH-1:0] rand_in,
    input  logic                  start,
    output logic                  busy,
    card_dealer_if.master         deal_if
);

    localparam int                 CNT_W      = IDX_WIDTH + 1;
    localparam int                 TRY_W      = $clog2(MAX_TRIES + 1);
    localparam int                 EXT_W      = 2 ** IDX_WIDTH;
    localparam logic [CNT_W-1:0]   LP_NUM     = CNT_W'(NUM_CARDS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [TRY_W-1:0]   TRY_ONE    = TRY_W'(1);
    localparam logic [TRY_W-1:0]   TRY_LIMIT  = TRY_W'(MAX_TRIES);

    dealer_state_e          r_state;
    dealer_state_e          w_next_state;
    logic [NUM_CARDS-1:0]   r_dealt;
    logic [IDX_WIDTH-1:0]   r_card_idx;
    logic [CNT_W-1:0]       r_deal_count;
    logic [TRY_W-1:0]       r_tries;
    logic                   r_done;

    logic [IDX_WIDTH-1:0]   w_cand;
    logic [EXT_W-1:0]       w_dealt_ext;
    logic                   w_cand_ok;
    logic [TRY_W-1:0]       w_tries_inc;
    logic                   w_tries_max;
    logic [CNT_W-1:0]       w_count_inc;
    logic                   w_last;
    logic [NUM_CARDS-1:0]   w_onehot;
    logic [IDX_WIDTH-1:0]   w_scan_idx;
    logic                   w_scan_found;
    logic                   w_card_valid;
    logic                   w_busy;
    logic                   w_unused_rand;

    // Only the low IDX_WIDTH bits form a candidate; the rest of the word is ignored.
    assign w_cand        = rand_in[IDX_WIDTH-1:0];
    assign w_unused_rand = ^rand_in;
    assign w_dealt_ext   = EXT_W'(r_dealt);
    assign w_cand_ok     = ({1'b0, w_cand} < LP_NUM) && !w_dealt_ext[w_cand];
    assign w_tries_inc   = r_tries + TRY_ONE;
    assign w_tries_max   = (w_tries_inc >= TRY_LIMIT);
    assign w_count_inc   = r_deal_count + CNT_ONE;
    assign w_last        = (w_count_inc == LP_NUM);
    assign w_onehot      = NUM_CARDS'(1) << r_card_idx;

    dealt_scan #(
        .NUM_CARDS (NUM_CARDS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_dealt_scan (
        .i_mask  (r_dealt),
        .o_idx   (w_scan_idx),
        .o_found (w_scan_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = DRAW;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DRAW: begin
                if (w_cand_ok) begin
                    w_next_state = OFFER;
                end else if (w_tries_max) begin
                    w_next_state = SCAN;
                end else begin
                    w_next_state = DRAW;
                end
            end
            SCAN: begin
                // A clear mask bit always exists while cards remain; abort otherwise.
                if (w_scan_found) begin
                    w_next_state = OFFER;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OFFER: begin
                if (deal_if.card_ready) begin
                    w_next_state = w_last ? IDLE : DRAW;
                end else begin
                    w_next_state = OFFER;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        w_busy       = 1'b0;
        w_card_valid = 1'b0;
        case (r_state)
            IDLE:    begin w_busy = 1'b0; w_card_valid = 1'b0; end
            DRAW:    begin w_busy = 1'b1; w_card_valid = 1'b0; end
            SCAN:    begin w_busy = 1'b1; w_card_valid = 1'b0; end
            OFFER:   begin w_busy = 1'b1; w_card_valid = 1'b1; end
            default: begin w_busy = 1'b0; w_card_valid = 1'b0; end
        endcase
    end

    // Deal datapath: dealt mask, latched card, accepted count, retry counter, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dealt      <= {NUM_CARDS{1'b0}};
            r_card_idx   <= {IDX_WIDTH{1'b0}};
            r_deal_count <= {CNT_W{1'b0}};
            r_tries      <= {TRY_W{1'b0}};
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dealt      <= {NUM_CARDS{1'b0}};
                        r_deal_count <= {CNT_W{1'b0}};
                        r_tries      <= {TRY_W{1'b0}};
                    end
                end
                DRAW: begin
                    if (w_cand_ok) begin
                        r_card_idx <= w_cand;
                        r_tries    <= {TRY_W{1'b0}};
                    end else begin
                        r_tries    <= w_tries_inc;
                    end
                end
                SCAN: begin
                    r_card_idx <= w_scan_idx;
                    r_tries    <= {TRY_W{1'b0}};
                end
                OFFER: begin
                    if (deal_if.card_ready) begin
                        r_dealt      <= r_dealt | w_onehot;
                        r_deal_count <= w_count_inc;
                        r_done       <= w_last;
                    end
                end
                default: begin
                    r_tries <= {TRY_W{1'b0}};
                end
            endcase
        end
    end

    assign busy               = w_busy;
    assign deal_if.card_valid = w_card_valid;
    assign deal_if.card_idx   = r_card_idx;
    assign deal_if.deal_count = r_deal_count;
    assign deal_if.done       = r_done;

`ifdef CARD_DEALER_STATS_EN
    logic [15:0] r_reject_total;
    logic        r_scan_used;

    // Per-deal rejection count (saturating) and sticky scan flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reject_total <= 16'h0000;
            r_scan_used    <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_reject_total <= 16'h0000;
            r_scan_used    <= 1'b0;
        end else begin
            if (r_state == DRAW && !w_cand_ok && r_reject_total != 16'hFFFF) begin
                r_reject_total <= r_reject_total + 16'h0001;
            end
            if (r_state == SCAN) begin
                r_scan_used <= 1'b1;
            end
        end
    end

    assign deal_if.reject_total = r_reject_total;
    assign deal_if.scan_used    = r_scan_used;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: vector table, then out-of-range, backpressure,
// stuck-RNG scan fallback and LFSR-driven full deals.
module tb_card_dealer;

    localparam int NC = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rand_in;
    logic        start;
    logic        busy;

    card_dealer_if #(.IDX_WIDTH(5)) dif ();

    card_dealer #(
        .RAND_WIDTH (32),
        .NUM_CARDS  (NC),
        .IDX_WIDTH  (5),
        .MAX_TRIES  (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rand_in (rand_in),
        .start   (start),
        .busy    (busy),
        .deal_if (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic        rdy;
        logic [31:0] rnd;
        logic        e_busy;
        logic        e_valid;
        logic [4:0]  e_idx;
        logic [5:0]  e_cnt;
        logic        e_done;
    } vec_t;

    vec_t        vecs [14];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] lfsr  = 32'hACE1_2468;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    initial begin
        int          got;
        int          last_seen;
        int          cyc;
        int          done_cnt;
        int          budget;
        logic [NC-1:0] seen;

        reset = 1'b1;
        start = 1'b0;
        rand_in = 32'h0000_0000;
        dif.card_ready = 1'b0;

        //        rst   st    rdy   rnd           busy  valid idx    cnt    done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  6'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 5'd0,  6'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0009, 1'b1, 1'b0, 5'd0,  6'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0005, 1'b1, 1'b1, 5'd5,  6'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0009, 1'b1, 1'b1, 5'd5,  6'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0009, 1'b1, 1'b0, 5'd5,  6'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 5'd5,  6'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_001F, 1'b1, 1'b0, 5'd5,  6'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0015, 1'b1, 1'b0, 5'd5,  6'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0014, 1'b1, 1'b1, 5'd20, 6'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFE3, 1'b1, 1'b0, 5'd20, 6'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b1, 5'd0,  6'd2, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 5'd0,  6'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 5'd0,  6'd0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst;
            start = vecs[i].st;
            dif.card_ready = vecs[i].rdy;
            rand_in = vecs[i].rnd;
            tick();
            chk($sformatf("v%0d_busy", i),  int'(busy),           int'(vecs[i].e_busy));
            chk($sformatf("v%0d_valid", i), int'(dif.card_valid), int'(vecs[i].e_valid));
            chk($sformatf("v%0d_idx", i),   int'(dif.card_idx),   int'(vecs[i].e_idx));
            chk($sformatf("v%0d_cnt", i),   int'(dif.deal_count), int'(vecs[i].e_cnt));
            chk($sformatf("v%0d_done", i),  int'(dif.done),       int'(vecs[i].e_done));
        end

        // Out-of-range candidates for 10 cycles, then 7.
        start = 1'b1;
        rand_in = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        chk("oor_busy", int'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            rand_in = 32'hFFFF_FFFF;
            tick();
            chk($sformatf("oor_wait%0d", k), int'(dif.card_valid), 0);
        end
        rand_in = 32'h1234_5667;
        tick();
        chk("oor_valid", int'(dif.card_valid), 1);
        chk("oor_idx", int'(dif.card_idx), 7);
`ifdef CARD_DEALER_STATS_EN
        chk("oor_rejects", int'(dif.reject_total), 10);
        chk("oor_scan_used", int'(dif.scan_used), 0);
`endif

        // Backpressure: card held for 50 cycles.
        dif.card_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            rand_in = $urandom;
            tick();
            chk($sformatf("bp_valid%0d", k), int'(dif.card_valid), 1);
            chk($sformatf("bp_idx%0d", k), int'(dif.card_idx), 7);
            chk($sformatf("bp_cnt%0d", k), int'(dif.deal_count), 0);
        end
        dif.card_ready = 1'b1;
        tick();
        chk("bp_accept_cnt", int'(dif.deal_count), 1);
        chk("bp_accept_valid", int'(dif.card_valid), 0);
        dif.card_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Stuck RNG: card 0 then scan-delivered 1..20, 18 cycles apart.
        rand_in = 32'h0000_0000;
        dif.card_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        last_seen = 0;
        cyc = 0;
        done_cnt = 0;
        budget = 1000;
        while (got < NC && budget > 0) begin
            start = 1'b0;
            if (dif.card_valid) begin
                chk($sformatf("stuck_idx%0d", got), int'(dif.card_idx), got);
                if (got > 0) begin
                    chk($sformatf("stuck_gap%0d", got), cyc - last_seen, 18);
                end
                // Start coincident with the final acceptance must be ignored.
                start = (got == NC - 1);
                last_seen = cyc;
                got++;
            end else begin
                // Start mid-deal while drawing must be ignored.
                start = (got == 8);
            end
            tick();
            cyc++;
            budget--;
            if (dif.done) done_cnt++;
        end
        start = 1'b0;
        chk("stuck_budget", got, NC);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dif.done) done_cnt++;
            chk($sformatf("stuck_idle_busy%0d", k), int'(busy), 0);
        end
        chk("stuck_done_pulses", done_cnt, 1);
        chk("stuck_count", int'(dif.deal_count), NC);
`ifdef CARD_DEALER_STATS_EN
        chk("stuck_rejects", int'(dif.reject_total), 16 * (NC - 1));
        chk("stuck_scan_used", int'(dif.scan_used), 1);
`endif

        // LFSR-driven deal with intermittent backpressure.
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = '0;
        got = 0;
        done_cnt = 0;
        budget = 5000;
        while (got < NC && budget > 0) begin
            lfsr = lfsr_next(lfsr);
            rand_in = lfsr;
            dif.card_ready = (lfsr[7:5] != 3'b000);
            if (dif.card_valid && dif.card_ready) begin
                if (int'(dif.card_idx) < NC) begin
                    chk($sformatf("lfsr_dup%0d", got), int'(seen[dif.card_idx]), 0);
                    seen[dif.card_idx] = 1'b1;
                end else begin
                    chk($sformatf("lfsr_range%0d", got), int'(dif.card_idx), NC - 1);
                end
                got++;
            end
            tick();
            budget--;
            if (dif.done) done_cnt++;
        end
        chk("lfsr_budget", got, NC);
        tick();
        if (dif.done) done_cnt++;
        chk("lfsr_all_seen", int'(&seen), 1);
        chk("lfsr_done_pulses", done_cnt, 1);
        chk("lfsr_count", int'(dif.deal_count), NC);
        chk("lfsr_busy_after", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
